// File: rtl/buffer_ctrl_pkg.sv
// Shared types and constants for the row buffer controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package buffer_ctrl_pkg;

    localparam int ROW_W = 16;
    localparam int COL_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_READ = 1'b1;

    // True when the requested row window runs past the end of the buffer.
    // Widened by one bit so base+rows can never wrap around.
    function automatic logic range_bad(input logic [ROW_W-1:0] base,
                                       input logic [ROW_W-1:0] rows,
                                       input logic [ROW_W:0]   limit);
        return ({1'b0, base} + {1'b0, rows}) > limit;
    endfunction

endpackage

// File: rtl/buffer_ctrl.sv
// Row buffer controller: streams LOAD words into the buffer and issues READ row fetches.
// Latency: writes driven in the accept cycle; row_valid one cycle after each read issue.
// Backpressure: in_ready only in LOAD; cmd_ready only in IDLE; reads never stall.
module buffer_ctrl
    import buffer_ctrl_pkg::*;
#(
    parameter int A = 60000,
    parameter int N = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [ROW_W-1:0] cmd_base,
    input  logic [ROW_W-1:0] cmd_rows,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             mem_enable,
    output logic             wr_rd,
    output logic [ROW_W-1:0] sel_a,
    output logic [COL_W-1:0] sel_n,
    output logic [31:0]      data_in,
    output logic             row_valid,
    output logic [ROW_W-1:0] row_idx,
    output logic             done,
    output logic             cmd_err,
    output logic             busy
);

    localparam logic [ROW_W:0]   A_LIM    = (ROW_W+1)'(A);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N - 1);

    state_t             state;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   remaining;

    logic cmd_fire;
    logic in_fire;
    logic last_row;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign in_ready  = (state == ST_LOAD);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign in_fire   = in_valid && in_ready;
    assign last_row  = (remaining == ROW_W'(1));

    // Buffer port is driven straight from the counters so a write lands in its accept cycle.
    always_comb begin
        mem_enable = 1'b0;
        wr_rd      = 1'b0;
        sel_a      = '0;
        sel_n      = '0;
        data_in    = '0;
        if (state == ST_LOAD && in_valid) begin
            mem_enable = 1'b1;
            wr_rd      = 1'b1;
            sel_a      = row;
            sel_n      = col;
            data_in    = in_data;
        end else if (state == ST_READ) begin
            mem_enable = 1'b1;
            sel_a      = row;
        end
    end

    // Control FSM: counters, state and the registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            row       <= '0;
            col       <= '0;
            remaining <= '0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
            row_valid <= 1'b0;
            row_idx   <= '0;
        end else begin
            done      <= 1'b0;
            cmd_err   <= 1'b0;
            row_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        if (range_bad(cmd_base, cmd_rows, A_LIM)) begin
                            cmd_err <= 1'b1;
                        end else if (cmd_rows == '0) begin
                            done <= 1'b1;
                        end else begin
                            row       <= cmd_base;
                            col       <= '0;
                            remaining <= cmd_rows;
                            state     <= (cmd_op == OP_READ) ? ST_READ : ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_fire) begin
                        if (col == COL_LAST) begin
                            col       <= '0;
                            row       <= row + ROW_W'(1);
                            remaining <= remaining - ROW_W'(1);
                            if (last_row) begin
                                state <= ST_IDLE;
                                done  <= 1'b1;
                            end
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                ST_READ: begin
                    // Buffer returns the row one cycle later; tag it to line up with the data.
                    row_valid <= 1'b1;
                    row_idx   <= row;
                    row       <= row + ROW_W'(1);
                    remaining <= remaining - ROW_W'(1);
                    if (last_row) begin
                        state <= ST_DRAIN;
                        done  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_ctrl.sv
// Bench for buffer_ctrl with a small attached buffer model (A=8, N=4).
// Latency: checks write timing, read-to-row_valid latency and done/cmd_err pulses.
// Backpressure: exercises in_valid gaps and a command held during LOAD.
module tb_buffer_ctrl;
    import buffer_ctrl_pkg::*;

    localparam int A = 8;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_op = 1'b0;
    logic [15:0] cmd_base = '0;
    logic [15:0] cmd_rows = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        mem_enable;
    logic        wr_rd;
    logic [15:0] sel_a;
    logic [7:0]  sel_n;
    logic [31:0] data_in;
    logic        row_valid;
    logic [15:0] row_idx;
    logic        done;
    logic        cmd_err;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_acc  = 0;

    always #5 clk = ~clk;

    buffer_ctrl #(.A(A), .N(N)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_rows(cmd_rows),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mem_enable(mem_enable), .wr_rd(wr_rd), .sel_a(sel_a), .sel_n(sel_n),
        .data_in(data_in), .row_valid(row_valid), .row_idx(row_idx),
        .done(done), .cmd_err(cmd_err), .busy(busy)
    );

    // Attached buffer: word writes, whole-row reads with one cycle latency.
    logic [31:0] bmem   [A][N];
    logic [31:0] rd_row [N];
    always @(posedge clk) begin
        if (mem_enable && wr_rd) bmem[sel_a[2:0]][sel_n[1:0]] <= data_in;
        if (mem_enable && !wr_rd) begin
            for (int c = 0; c < N; c++) rd_row[c] <= bmem[sel_a[2:0]][c];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (!rst && cmd_valid && cmd_ready) n_acc <= n_acc + 1;

    // Reference contents: what the buffer must hold after each completed LOAD.
    logic [31:0] ref_mem [A][N];
    bit          ref_ok  [A];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_chk(input string t);
        chk({t, "_men"},  32'(mem_enable), 32'(0));
        chk({t, "_wrrd"}, 32'(wr_rd),      32'(0));
        chk({t, "_sela"}, 32'(sel_a),      32'(0));
        chk({t, "_seln"}, 32'(sel_n),      32'(0));
        chk({t, "_din"},  data_in,         32'(0));
        chk({t, "_rv"},   32'(row_valid),  32'(0));
        chk({t, "_ridx"}, 32'(row_idx),    32'(0));
        chk({t, "_done"}, 32'(done),       32'(0));
        chk({t, "_err"},  32'(cmd_err),    32'(0));
        chk({t, "_busy"}, 32'(busy),       32'(0));
        chk({t, "_inr"},  32'(in_ready),   32'(0));
        chk({t, "_cmdr"}, 32'(cmd_ready),  32'(1));
    endtask

    task automatic present(input logic op, input int base, input int rows);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_base  = 16'(base);
        cmd_rows  = 16'(rows);
    endtask

    task automatic row_data_chk(input int r);
        if (r >= 0 && r < A && ref_ok[r]) begin
            for (int c = 0; c < N; c++) chk("rd_data", rd_row[c], ref_mem[r][c]);
        end
    endtask

    // gap_mode: 0 = word every cycle, 1 = every other cycle, 2 = random gaps.
    task automatic do_load(input int base, input int rows, input int gap_mode,
                           input bit fixed_data, input int data0, input bit chk_lat,
                           input bit hold, input int nb, input int nr);
        int total, k, it, t0;
        bit v;
        logic [31:0] word;
        present(OP_LOAD, base, rows);
        @(negedge clk);
        chk("ld_acc_rdy", 32'(cmd_ready), 32'(1));
        tick();
        if (hold) present(OP_READ, nb, nr);
        else cmd_valid = 1'b0;
        total = rows * N;
        k = 0; it = 0; t0 = 0;
        while (k < total && it < 4 * total + 8) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (it % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            word     = fixed_data ? 32'(data0 + k) : $urandom;
            in_valid = v;
            in_data  = word;
            @(negedge clk);
            chk("ld_inr",  32'(in_ready),   32'(1));
            chk("ld_cmdr", 32'(cmd_ready),  32'(0));
            chk("ld_busy", 32'(busy),       32'(1));
            chk("ld_done", 32'(done),       32'(0));
            chk("ld_men",  32'(mem_enable), 32'(v));
            if (v) begin
                chk("ld_wrrd", 32'(wr_rd),   32'(1));
                chk("ld_sela", 32'(sel_a),   32'(base + k / N));
                chk("ld_seln", 32'(sel_n),   32'(k % N));
                chk("ld_din",  data_in,      word);
                ref_mem[base + k / N][k % N] = word;
                if (k == 0) t0 = cyc;
                k++;
            end
            tick();
            it++;
        end
        chk("ld_words", 32'(k), 32'(total));
        in_valid = 1'b0;
        @(negedge clk);
        chk("ld_end_done", 32'(done),       32'(1));
        chk("ld_end_err",  32'(cmd_err),    32'(0));
        chk("ld_end_cmdr", 32'(cmd_ready),  32'(1));
        chk("ld_end_busy", 32'(busy),       32'(0));
        chk("ld_end_men",  32'(mem_enable), 32'(0));
        if (chk_lat) chk("ld_done_lat", 32'(cyc - t0), 32'(total));
        for (int r = 0; r < rows; r++) ref_ok[base + r] = 1'b1;
        tick();
    endtask

    // pre: the command was already accepted at the previous edge.
    task automatic do_read(input int base, input int rows, input bit pre);
        if (!pre) begin
            present(OP_READ, base, rows);
            @(negedge clk);
            chk("rd_acc_rdy", 32'(cmd_ready), 32'(1));
            tick();
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < rows; i++) begin
            @(negedge clk);
            chk("rd_men",  32'(mem_enable), 32'(1));
            chk("rd_wrrd", 32'(wr_rd),      32'(0));
            chk("rd_sela", 32'(sel_a),      32'(base + i));
            chk("rd_seln", 32'(sel_n),      32'(0));
            chk("rd_busy", 32'(busy),       32'(1));
            chk("rd_cmdr", 32'(cmd_ready),  32'(0));
            chk("rd_inr",  32'(in_ready),   32'(0));
            chk("rd_done", 32'(done),       32'(0));
            chk("rd_rv",   32'(row_valid),  32'(i > 0));
            if (i > 0) begin
                chk("rd_ridx", 32'(row_idx), 32'(base + i - 1));
                row_data_chk(base + i - 1);
            end
            tick();
        end
        @(negedge clk);
        chk("dr_men",  32'(mem_enable), 32'(0));
        chk("dr_rv",   32'(row_valid),  32'(1));
        chk("dr_ridx", 32'(row_idx),    32'(base + rows - 1));
        chk("dr_done", 32'(done),       32'(1));
        chk("dr_busy", 32'(busy),       32'(1));
        row_data_chk(base + rows - 1);
        tick();
        @(negedge clk);
        chk("rd_end_rv",   32'(row_valid), 32'(0));
        chk("rd_end_done", 32'(done),      32'(0));
        chk("rd_end_cmdr", 32'(cmd_ready), 32'(1));
        tick();
    endtask

    // Commands that finish in IDLE: out-of-range (cmd_err) or zero rows (done).
    task automatic do_short(input logic op, input int base, input int rows, input bit exp_err);
        present(op, base, rows);
        @(negedge clk);
        chk("sh_acc_rdy", 32'(cmd_ready),  32'(1));
        chk("sh_acc_men", 32'(mem_enable), 32'(0));
        tick();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("sh_err",  32'(cmd_err),    32'(exp_err));
        chk("sh_done", 32'(done),       32'(!exp_err));
        chk("sh_men",  32'(mem_enable), 32'(0));
        chk("sh_busy", 32'(busy),       32'(0));
        tick();
        @(negedge clk);
        chk("sh_err2",  32'(cmd_err), 32'(0));
        chk("sh_done2", 32'(done),    32'(0));
        tick();
    endtask

    initial begin
        int acc0, op, b, r;
        for (int i = 0; i < A; i++) begin
            ref_ok[i] = 1'b0;
            for (int c = 0; c < N; c++) ref_mem[i][c] = '0;
        end

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        reset_chk("rst");
        tick();
        rst = 1'b0;

        // LOAD base=2 rows=2, words 0x10.., no gaps, done 8 cycles after first word
        do_load(2, 2, 0, 1'b1, 'h10, 1'b1, 1'b0, 0, 0);
        // LOAD base=0 rows=1 with gaps every other cycle
        do_load(0, 1, 1, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        // READ back rows 2..3
        do_read(2, 2, 1'b0);

        // Range and zero-row boundaries
        do_short(OP_LOAD, 6, 3, 1'b1);
        do_short(OP_READ, 8, 0, 1'b0);
        do_short(OP_READ, 'hFFFF, 2, 1'b1);
        do_load(6, 2, 2, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        do_read(6, 2, 1'b0);

        // Reset in the middle of a READ, after the first issue
        present(OP_READ, 0, 3);
        @(negedge clk);
        chk("mr_acc_rdy", 32'(cmd_ready), 32'(1));
        tick();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mr_issue", 32'(mem_enable), 32'(1));
        rst = 1'b1;
        tick();
        @(negedge clk);
        reset_chk("mr");
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("mr_nodone", 32'(done),      32'(0));
        chk("mr_norv",   32'(row_valid), 32'(0));
        tick();
        do_read(0, 1, 1'b0);

        // Command held during LOAD: the queued READ is taken exactly once
        acc0 = n_acc;
        do_load(4, 1, 0, 1'b0, 0, 1'b0, 1'b1, 4, 1);
        do_read(4, 1, 1'b1);
        chk("hold_accepts", 32'(n_acc - acc0), 32'(2));

        // Random commands dispatched through the reference rules
        for (int t = 0; t < 10; t++) begin
            op = int'($urandom_range(0, 1));
            b  = int'($urandom_range(0, 9));
            r  = int'($urandom_range(0, 4));
            if (b + r > A)      do_short(1'(op), b, r, 1'b1);
            else if (r == 0)    do_short(1'(op), b, r, 1'b0);
            else if (op == 0)   do_load(b, r, 2, 1'b0, 0, 1'b0, 1'b0, 0, 0);
            else                do_read(b, r, 1'b0);
        end

        // Buffer contents against the reference after all loads
        for (int i = 0; i < A; i++) begin
            if (ref_ok[i]) begin
                for (int c = 0; c < N; c++) chk("final_mem", bmem[i][c], ref_mem[i][c]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/buffer_ctrl.md
BUFFER_CTRL -- requirements
Module: buffer_ctrl

Interface
REQ-001 SHALL have parameters: A, 60000, buffer row count (1..65536); N, 256, words per row (1..256).
REQ-002 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_op in 1 (0=LOAD, 1=READ), cmd_base in 16 (first row), cmd_rows in 16 (row count).
REQ-005 SHALL have ports in_valid in 1, in_ready out 1, in_data in 32: load word stream, row-major.
REQ-006 SHALL have buffer-side ports mem_enable out 1, wr_rd out 1 (1=write), sel_a out 16, sel_n out 8, data_in out 32.
REQ-007 SHALL have ports row_valid out 1, row_idx out 16 (row now on buffer data_out_mem), done out 1, cmd_err out 1, busy out 1.

Function
REQ-008 SHALL implement FSM states IDLE, LOAD, READ, DRAIN.
REQ-009 IDLE: cmd_ready=1, busy=0; command accepted on cmd_valid&&cmd_ready.
REQ-010 On accept with cmd_base+cmd_rows > A (17-bit compare, no wrap), SHALL stay IDLE and pulse cmd_err one cycle later; no buffer access.
REQ-011 On accept with cmd_rows==0 and in range, SHALL stay IDLE and pulse done one cycle later.
REQ-012 Otherwise SHALL load row counter=cmd_base, col counter=0, remaining=cmd_rows, enter LOAD or READ next cycle.
REQ-013 LOAD: in_ready=1; each in_valid&&in_ready cycle drives mem_enable=1, wr_rd=1, sel_a=row, sel_n=col, data_in=in_data combinationally in that same cycle.
REQ-014 LOAD: col increments per accepted word; at col==N-1 col wraps to 0 and row increments; no buffer access in cycles with in_valid=0.
REQ-015 LOAD: word at (cmd_base+cmd_rows-1, N-1) SHALL be last; FSM returns to IDLE next cycle and done pulses that cycle.
REQ-016 READ: SHALL issue one read per cycle, mem_enable=1, wr_rd=0, sel_a=row, sel_n=0, rows cmd_base..cmd_base+cmd_rows-1 consecutively, no stalls.
REQ-017 row_valid SHALL assert exactly one cycle after each read issue with row_idx = row issued (buffer read latency 1).
REQ-018 After the last issue SHALL enter DRAIN for one cycle (last row_valid), pulse done in that DRAIN cycle, then IDLE.
REQ-019 cmd_ready=0, busy=1 in LOAD, READ, DRAIN; cmd_valid ignored there.
REQ-020 in_ready=0 outside LOAD; mem_enable=0 in IDLE and DRAIN.
REQ-021 done, cmd_err, row_valid SHALL be single-cycle pulses; done and cmd_err never in the same cycle.

Reset
REQ-022 rst SHALL force IDLE, counters 0, and next cycle: mem_enable=0, wr_rd=0, sel_a=0, sel_n=0, data_in=0, row_valid=0, row_idx=0, done=0, cmd_err=0, busy=0, in_ready=0, cmd_ready=1.
REQ-023 rst mid-LOAD/READ SHALL abort with no done pulse; partially written rows are left as is.
REQ-024 rst SHALL NOT be forwarded to or clear the buffer.

Structure
REQ-025 Shared package SHALL hold FSM state enum, op encoding (OP_LOAD/OP_READ), and address widths (ROW_W=16, COL_W=8).
REQ-026 Single module; no sub-module required; state, row/col/remaining counters are registers.

Verification (bench params A=8, N=4, model buffer attached)
REQ-027 LOAD base=2 rows=2, words 0x10..0x17, in_valid always 1 -> writes (2,0)..(3,3) in order, done 8 cycles after first word.
REQ-028 LOAD base=0 rows=1 with in_valid gaps every other cycle -> 4 writes only on valid cycles, no write on gap cycles, done after 4th.
REQ-029 READ base=2 rows=2 after REQ-027 -> row_valid 2 consecutive cycles, row_idx 2 then 3, data 0x10..0x13 / 0x14..0x17, done with 2nd.
REQ-030 LOAD base=6 rows=3 -> cmd_err pulse, no mem_enable; READ rows=0 base=8 -> done pulse, no access.
REQ-031 rst asserted mid-READ after first issue -> next cycle all outputs at reset values, no done; next command accepted normally.
REQ-032 cmd_valid held during LOAD -> cmd_ready=0 until IDLE, command accepted exactly once afterwards.
